// File: rtl/fa_seq_pkg.sv
// Shared types for the full-adder vector sequencer: FSM states, the {B, A, CIN}
// stimulus vector and the ideal full-adder response.
package fa_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY_I = 2'd1,
        ST_APPLY_J = 2'd2,
        ST_FINISH  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic b;
        logic a;
        logic cin;
    } fa_vec_t;

    // Ideal full-adder result for one vector, packed as {COUT, S}.
    function automatic logic [1:0] fa_expect(input fa_vec_t vec);
        logic s;
        logic cout;
        s    = vec.b ^ vec.a ^ vec.cin;
        cout = (vec.b & vec.a) | (vec.b & vec.cin) | (vec.a & vec.cin);
        return {cout, s};
    endfunction

endpackage

// File: rtl/fa_resp_checker.sv
// Response checker: compares the adder's {COUT, S} with the ideal result on a
// sample strobe, pulses mismatch one cycle later and keeps a saturating count.
module fa_resp_checker
    import fa_seq_pkg::*;
#(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample,
    input  fa_vec_t          vec,
    input  logic             s,
    input  logic             cout,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    logic fail;

    assign fail = sample && (fa_expect(vec) != {cout, s});

    // NOTE: sequential state is always assigned with <= so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            mismatch <= fail;
            if (clear) begin
                err_cnt <= '0;
            end else if (fail && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fa_vector_sequencer.sv
// Pairwise stimulus sequencer for a full adder with optional response checking.
// Define FA_SEQ_CHECK_EN to build in the checker; otherwise MISMATCH/ERR_CNT are 0.
module fa_vector_sequencer
    import fa_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int DWELL = 50,
    parameter int ERR_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 VEC_WE,
    input  logic [$clog2(N)-1:0] VEC_ADDR,
    input  logic [2:0]           VEC_DATA,
    input  logic                 S,
    input  logic                 COUT,
    output logic                 B,
    output logic                 A,
    output logic                 CIN,
    output logic [$clog2(N)-1:0] IDX,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 MISMATCH,
    output logic [ERR_W-1:0]     ERR_CNT
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DWELL);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);

    seq_state_t    state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire;
    logic          applying;
    logic          run_clear;
    logic [IW-1:0] cur_idx;
    fa_vec_t       cur_vec;
    logic          sample_q;
    fa_vec_t       vec_mem [N];

    // NOTE: the vector store has no reset so its contents survive RST; it is
    // plain storage and a reset would only add fan-out to every bit.
    always_ff @(posedge CLK) begin
        if (VEC_WE && !BUSY) begin
            vec_mem[VEC_ADDR] <= fa_vec_t'(VEC_DATA);
        end
    end

    assign expire    = (cnt_q == '0);
    assign applying  = (state_q == ST_APPLY_I) || (state_q == ST_APPLY_J);
    assign run_clear = (state_q == ST_IDLE) && START;
    assign cur_idx   = (state_q == ST_APPLY_J) ? j_q : i_q;
    assign cur_vec   = vec_mem[cur_idx];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_APPLY_I;
                    i_d     = '0;
                    j_d     = '0;
                    cnt_d   = DWELL_LOAD;
                end
            end
            ST_APPLY_I: begin
                if (expire) begin
                    state_d = ST_APPLY_J;
                    cnt_d   = DWELL_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_APPLY_J: begin
                if (expire) begin
                    cnt_d = DWELL_LOAD;
                    if (j_q < LAST_IDX) begin
                        j_d     = j_q + 1'b1;
                        state_d = ST_APPLY_I;
                    end else if (i_q < LAST_IDX) begin
                        // Next row starts on its own diagonal: j = new i.
                        i_d     = i_q + 1'b1;
                        j_d     = i_q + 1'b1;
                        state_d = ST_APPLY_I;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage trails the state register by one cycle, so the sample
    // strobe lands on the last cycle each vector is actually on the pins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            {B, A, CIN} <= 3'b000;
            IDX         <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            sample_q    <= 1'b0;
        end else begin
            {B, A, CIN} <= applying ? cur_vec : 3'b000;
            IDX         <= applying ? cur_idx : '0;
            BUSY        <= applying;
            DONE        <= (state_q == ST_FINISH);
            sample_q    <= applying && expire;
        end
    end

`ifdef FA_SEQ_CHECK_EN
    fa_resp_checker #(
        .ERR_W (ERR_W)
    ) u_resp_checker (
        .clk      (CLK),
        .rst      (RST),
        .clear    (run_clear),
        .sample   (sample_q),
        .vec      (fa_vec_t'({B, A, CIN})),
        .s        (S),
        .cout     (COUT),
        .mismatch (MISMATCH),
        .err_cnt  (ERR_CNT)
    );
`else
    logic unused_chk;

    assign MISMATCH   = 1'b0;
    assign ERR_CNT    = '0;
    assign unused_chk = ^{S, COUT, sample_q, run_clear};
`endif

endmodule

// File: tb/tb_fa_vector_sequencer.sv
// Randomised self-checking bench for fa_vector_sequencer against a pair-list
// reference model and a faultable behavioural adder.
module tb_fa_vector_sequencer;

    localparam int N     = 8;
    localparam int DWELL = 4;
    localparam int ERR_W = 16;
    localparam int IW    = $clog2(N);
    localparam int RUN   = N * (N + 1) * DWELL;
`ifdef FA_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic             VEC_WE;
    logic [IW-1:0]    VEC_ADDR;
    logic [2:0]       VEC_DATA;
    logic             S;
    logic             COUT;
    logic             B;
    logic             A;
    logic             CIN;
    logic [IW-1:0]    IDX;
    logic             BUSY;
    logic             DONE;
    logic             MISMATCH;
    logic [ERR_W-1:0] ERR_CNT;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] shadow [N];
    int         fault_mode;
    logic [2:0] fault_vec;

    always #5 CLK = ~CLK;

    fa_vector_sequencer #(
        .N     (N),
        .DWELL (DWELL),
        .ERR_W (ERR_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .VEC_WE   (VEC_WE),
        .VEC_ADDR (VEC_ADDR),
        .VEC_DATA (VEC_DATA),
        .S        (S),
        .COUT     (COUT),
        .B        (B),
        .A        (A),
        .CIN      (CIN),
        .IDX      (IDX),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .MISMATCH (MISMATCH),
        .ERR_CNT  (ERR_CNT)
    );

    // {COUT, S} from counting ones: COUT = ones/2, S = ones%2.
    function automatic logic [1:0] ideal_resp(input logic [2:0] v);
        int ones;
        ones = int'(v[2]) + int'(v[1]) + int'(v[0]);
        return {ones >= 2, (ones % 2) == 1};
    endfunction

    // Adder under test: 0 ideal, 1 S stuck at 0, 2 COUT inverted for one vector.
    function automatic logic [1:0] adder_resp(input logic [2:0] v, input int mode,
                                              input logic [2:0] fv);
        logic [1:0] r;
        r = ideal_resp(v);
        if (mode == 1) r[0] = 1'b0;
        if (mode == 2 && v == fv) r[1] = ~r[1];
        return r;
    endfunction

    assign {COUT, S} = adder_resp({B, A, CIN}, fault_mode, fault_vec);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_vec(input int addr, input logic [2:0] data);
        VEC_WE   = 1'b1;
        VEC_ADDR = IW'(addr);
        VEC_DATA = data;
        @(posedge CLK); #1;
        VEC_WE   = 1'b0;
        shadow[addr] = data;
    endtask

    // One run from START; noise injects START/VEC_WE while busy, rst_at > 0
    // asserts RST during cycle rst_at of the run.
    task automatic run_seq(input string tag, input bit noise, input int rst_at);
        int         exp_idx[$];
        bit         app_fail[$];
        int         seq_err;
        int         pulses;
        int         done_at;
        int         errs;
        int         dones;
        int         e_idx;
        logic [2:0] e_stim;
        bit         e_busy;
        bit         e_done;
        bit         e_mm;
        logic [31:0] err_at_done;

        seq_err = 0; pulses = 0; done_at = -1; errs = 0; dones = 0; err_at_done = '1;
        for (int i = 0; i < N; i++) begin
            for (int j = i; j < N; j++) begin
                exp_idx.push_back(i);
                exp_idx.push_back(j);
            end
        end
        foreach (exp_idx[k]) begin
            bit f;
            f = adder_resp(shadow[exp_idx[k]], fault_mode, fault_vec) != ideal_resp(shadow[exp_idx[k]]);
            app_fail.push_back(f);
            if (f) errs++;
        end

        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        if (BUSY !== 1'b0) seq_err++;

        for (int c = 1; c <= RUN + 1; c++) begin
            @(posedge CLK); #1;
            if (rst_at > 0 && c == rst_at + 1) begin
                RST = 1'b0;
                check({tag, " outputs_after_rst"},
                      32'({B, A, CIN, IDX, BUSY, DONE, MISMATCH, ERR_CNT}), 32'd0);
                break;
            end
            if (c <= RUN) begin
                e_idx  = exp_idx[(c - 1) / DWELL];
                e_stim = shadow[e_idx];
                e_busy = 1'b1;
                e_done = 1'b0;
            end else begin
                e_idx  = 0;
                e_stim = 3'b000;
                e_busy = 1'b0;
                e_done = 1'b1;
            end
            e_mm = CHK && (c > DWELL) && ((c - 1) % DWELL == 0) && app_fail[(c - 1) / DWELL - 1];
            if ({B, A, CIN} !== e_stim || IDX !== IW'(e_idx) || BUSY !== e_busy ||
                DONE !== e_done || MISMATCH !== e_mm) begin
                seq_err++;
            end
            if (MISMATCH === 1'b1) pulses++;
            if (DONE === 1'b1) begin
                done_at     = c;
                err_at_done = 32'(ERR_CNT);
            end
            START  = 1'b0;
            VEC_WE = 1'b0;
            if (noise && c <= RUN) begin
                START    = 1'($urandom_range(1));
                VEC_WE   = ($urandom_range(3) == 0);
                VEC_ADDR = IW'($urandom_range(N - 1));
                VEC_DATA = 3'($urandom_range(7));
            end
            if (rst_at > 0 && c == rst_at) RST = 1'b1;
        end
        START  = 1'b0;
        VEC_WE = 1'b0;

        if (rst_at > 0) begin
            repeat (RUN + 4) begin
                @(posedge CLK); #1;
                if (DONE === 1'b1) dones++;
            end
            check({tag, " done_after_rst"}, 32'(dones), 32'd0);
        end else begin
            check({tag, " sequence"}, 32'(seq_err), 32'd0);
            check({tag, " done_cycle"}, 32'(done_at), 32'(RUN + 1));
            check({tag, " mismatch_pulses"}, 32'(pulses), CHK ? 32'(errs) : 32'd0);
            check({tag, " err_cnt_at_done"}, err_at_done, CHK ? 32'(errs) : 32'd0);
            @(posedge CLK); #1;
            check({tag, " done_one_cycle"}, 32'({DONE, BUSY}), 32'd0);
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; VEC_WE = 1'b0; VEC_ADDR = '0; VEC_DATA = '0;
        fault_mode = 0; fault_vec = 3'b000;
        repeat (2) @(posedge CLK);
        #1;
        check("rst stim", 32'({B, A, CIN}), 32'd0);
        check("rst idx", 32'(IDX), 32'd0);
        check("rst busy", 32'(BUSY), 32'd0);
        check("rst done", 32'(DONE), 32'd0);
        check("rst mismatch", 32'(MISMATCH), 32'd0);
        check("rst err_cnt", 32'(ERR_CNT), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        for (int k = 0; k < N; k++) write_vec(k, 3'(k));
        run_seq("clean", 1'b0, 0);

        fault_mode = 1;
        run_seq("stuck_s", 1'b0, 0);

        fault_mode = 0;
        run_seq("busy_noise", 1'b1, 0);
        run_seq("after_noise", 1'b0, 0);

        fault_mode = 1;
        run_seq("rst_mid", 1'b0, 100);
        run_seq("replay", 1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) write_vec(k, 3'($urandom_range(7)));
            fault_mode = 2;
            fault_vec  = 3'($urandom_range(7));
            run_seq($sformatf("random%0d", r), 1'($urandom_range(1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
